// File: rtl/add_bist.sv
// Built-in self-test for the registered adder: issues corner-case and LFSR operand pairs,
// predicts each sum, and checks the adder's result once its latency has elapsed.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | one vector issued per cycle
// DRAIN | last vector held on dut_in*, outstanding checks retiring
// DONE  | results frozen; start begins a new run
module add_bist #(
    parameter int          WIDTH       = 8,
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LATENCY = 1,
    parameter logic [31:0] SEED        = 32'h1,
    parameter int          ERR_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in0,
    output logic [WIDTH-1:0] dut_in1,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx
);

    localparam logic [31:0] TAPS     = 32'h80200003;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [31:0]          lfsr, lfsr_step;
    logic [15:0]          vec_idx, chk_idx;
    logic [WIDTH-1:0]     vec_in0, vec_in1;
    logic [WIDTH-1:0]     exp_pipe [DUT_LATENCY];
    logic [DUT_LATENCY-1:0] exp_vld;
    logic                 launch, issue, check, mismatch;

    assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    assign launch    = start && (state == S_IDLE || state == S_DONE);
    assign issue     = (state == S_RUN);
    assign check     = (state == S_RUN || state == S_DRAIN) && exp_vld[DUT_LATENCY-1];
    assign mismatch  = check && (dut_out != exp_pipe[DUT_LATENCY-1]);

    // Vector 0 is loaded directly on launch; this selects vectors 1..N-1.
    always_comb begin
        vec_in0 = lfsr_step[WIDTH-1:0];
        vec_in1 = lfsr_step[31:32-WIDTH];
        if (vec_idx == 16'd1) begin
            vec_in0 = '1;
            vec_in1 = WIDTH'(1);
        end else if (vec_idx == 16'd2) begin
            vec_in0 = '1;
            vec_in1 = '1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch) state_nxt = S_RUN;
            S_RUN:   if (vec_idx == LAST_IDX) state_nxt = S_DRAIN;
            S_DRAIN: if (check && chk_idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:  if (launch) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN) || (state == S_DRAIN);
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_count == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dut_in0       <= '0;
            dut_in1       <= '0;
            lfsr          <= SEED;
            vec_idx       <= '0;
            chk_idx       <= '0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
            exp_vld       <= '0;
            for (int k = 0; k < DUT_LATENCY; k++) exp_pipe[k] <= '0;
        end else begin
            for (int k = DUT_LATENCY - 1; k > 0; k--) begin
                exp_pipe[k] <= exp_pipe[k-1];
                exp_vld[k]  <= exp_vld[k-1];
            end
            exp_vld[0]  <= issue || launch;
            exp_pipe[0] <= launch ? '0 : WIDTH'(vec_in0 + vec_in1);

            if (launch) begin
                dut_in0       <= '0;
                dut_in1       <= '0;
                lfsr          <= SEED;
                vec_idx       <= 16'd1;
                chk_idx       <= '0;
                err_count     <= '0;
                first_err_idx <= 16'hFFFF;
            end else if (issue) begin
                dut_in0 <= vec_in0;
                dut_in1 <= vec_in1;
                vec_idx <= vec_idx + 16'd1;
                if (vec_idx >= 16'd3) lfsr <= lfsr_step;
            end

            if (check) begin
                chk_idx <= chk_idx + 16'd1;
                if (mismatch) begin
                    if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
                    if (first_err_idx == 16'hFFFF) first_err_idx <= chk_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_bist.sv
// Drives four add_bist instances against adder models: ideal, bit1 stuck-at-1,
// and a three-edge delayed adder checked with matching and mismatched latency.
module tb_add_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b, start_c, start_d;
    logic [7:0] in0_a, in1_a, out_a, in0_b, in1_b, out_b;
    logic [7:0] in0_c, in1_c, out_c, in0_d, in1_d, out_d;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic busy_c, done_c, pass_c, busy_d, done_d, pass_d;
    logic [15:0] err_a, err_b, err_c, err_d;
    logic [15:0] first_a, first_b, first_c, first_d;
    logic [7:0] r1_c, r2_c, r1_d, r2_d;

    int checks = 0;
    int failures = 0;

    // Adder models; the delayed one reaches the sampling edge three edges after its inputs.
    assign out_a = in0_a + in1_a;
    assign out_b = (in0_b + in1_b) | 8'h02;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_c <= '0; r2_c <= '0; r1_d <= '0; r2_d <= '0;
        end else begin
            r1_c <= in0_c + in1_c; r2_c <= r1_c;
            r1_d <= in0_d + in1_d; r2_d <= r1_d;
        end
    end
    assign out_c = r2_c;
    assign out_d = r2_d;

    add_bist #(.WIDTH(8), .NUM_VECTORS(4), .DUT_LATENCY(1)) u_a (
        .clock(clk), .reset(rst), .start(start_a), .dut_in0(in0_a), .dut_in1(in1_a),
        .dut_out(out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_idx(first_a));
    add_bist #(.WIDTH(8), .NUM_VECTORS(3), .DUT_LATENCY(1)) u_b (
        .clock(clk), .reset(rst), .start(start_b), .dut_in0(in0_b), .dut_in1(in1_b),
        .dut_out(out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(first_b));
    add_bist #(.WIDTH(8), .NUM_VECTORS(16), .DUT_LATENCY(3)) u_c (
        .clock(clk), .reset(rst), .start(start_c), .dut_in0(in0_c), .dut_in1(in1_c),
        .dut_out(out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_idx(first_c));
    add_bist #(.WIDTH(8), .NUM_VECTORS(16), .DUT_LATENCY(1)) u_d (
        .clock(clk), .reset(rst), .start(start_d), .dut_in0(in0_d), .dut_in1(in1_d),
        .dut_out(out_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .err_count(err_d), .first_err_idx(first_d));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] sum;
        logic       busy;
        logic       done;
    } row_t;

    row_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Observed after e0..e4 for NUM_VECTORS=4, LFSR step 1 from seed 1 = 80200003.
        tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        tbl[3] = '{8'h03, 8'h80, 8'h83, 1'b1, 1'b0};
        tbl[4] = '{8'h03, 8'h80, 8'h83, 1'b0, 1'b1};

        rst = 1'b1;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_first", first_a, 16'hFFFF);
        chk("rst_in", {in0_a, in1_a}, 16'h0000);

        // Basic run with the vector table.
        @(negedge clk) start_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            chk($sformatf("a_in0[%0d]", k), in0_a, tbl[k].in0);
            chk($sformatf("a_in1[%0d]", k), in1_a, tbl[k].in1);
            chk($sformatf("a_sum[%0d]", k), out_a, tbl[k].sum);
            chk($sformatf("a_busy[%0d]", k), busy_a, tbl[k].busy);
            chk($sformatf("a_done[%0d]", k), done_a, tbl[k].done);
        end
        chk("a_pass", pass_a, 1);
        chk("a_err", err_a, 0);
        chk("a_first", first_a, 16'hFFFF);
        @(posedge clk); #1;
        chk("a_done_held", done_a, 1);

        // Stuck bit1: vectors 0 and 1 (sum 00) fail, vector 2 (FE) is unaffected.
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("b_ignore_busy", busy_b, 1);
        chk("b_ignore_in", {in0_b, in1_b}, 16'hFF01);
        @(posedge clk); #1;
        chk("b_done_e2", done_b, 0);
        @(posedge clk); #1;
        chk("b_done_e3", done_b, 1);
        chk("b_err", err_b, 2);
        chk("b_first", first_b, 0);
        chk("b_pass", pass_b, 0);

        // Restart from DONE clears results.
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("b_rs_busy", busy_b, 1);
        chk("b_rs_done", done_b, 0);
        chk("b_rs_err", err_b, 0);
        chk("b_rs_first", first_b, 16'hFFFF);
        chk("b_rs_pass", pass_b, 0);
        chk("b_rs_in", {in0_b, in1_b}, 16'h0000);
        n = 0;
        while (!done_b && n < 20) begin @(posedge clk); #1; n++; end
        chk("b_rs_finished", done_b, 1);
        chk("b_rs_err2", err_b, 2);

        // Latency 3 matched vs latency 1 against the same delayed adder.
        @(negedge clk) begin start_c = 1'b1; start_d = 1'b1; end
        @(posedge clk); #1;
        start_c = 1'b0; start_d = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            if (k == 15) chk("d_done_e15", done_d, 0);
            if (k == 16) chk("d_done_e16", done_d, 1);
            if (k == 17) chk("c_done_e17", done_c, 0);
            if (k == 18) chk("c_done_e18", done_c, 1);
        end
        chk("c_pass", pass_c, 1);
        chk("c_err", err_c, 0);
        chk("d_pass", pass_d, 0);
        chk("d_first", first_d, 2);

        // Reset in the middle of a run.
        @(negedge clk) start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("c_vec5", {in0_c, in1_c}, 16'h0160);
        #2 rst = 1'b1;
        #1;
        chk("mr_busy", busy_c, 0);
        chk("mr_done", done_c, 0);
        chk("mr_in", {in0_c, in1_c}, 16'h0000);
        chk("mr_err", err_c, 0);
        chk("mr_first", first_c, 16'hFFFF);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("mr_idle_done", done_c, 0);
        @(negedge clk) start_c = 1'b1;
        @(posedge clk); #1;
        start_c = 1'b0;
        chk("mr_rerun_in", {in0_c, in1_c}, 16'h0000);
        n = 0;
        while (!done_c && n < 40) begin @(posedge clk); #1; n++; end
        chk("mr_rerun_edges", n, 18);
        chk("mr_rerun_pass", pass_c, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
